// File: rtl/ad_pack_buff.sv
// ad_pack_buff: triggered A/D capture buffer packing PACK samples per output word.
// Optional macro AD_PACK_RAMP_EN adds i_ramp, selecting an internal test ramp instead of i_ad_data.
module ad_pack_buff #(
    parameter int DSIZE = 8,
    parameter int PACK  = 2,
    parameter int CNT_W = 16,
    parameter int DLY_W = 8
) (
    input  logic                  i_ad_clk,
    input  logic                  i_rst,
    input  logic                  i_st,
    input  logic                  i_abort,
`ifdef AD_PACK_RAMP_EN
    input  logic                  i_ramp,
`endif
    input  logic [DSIZE-1:0]      i_ad_data,
    input  logic [CNT_W-1:0]      i_recv_count,
    input  logic [DLY_W-1:0]      i_delay,
    output logic [DSIZE*PACK-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_last,
    output logic                  o_working,
    output logic                  o_done
);

    localparam int WW  = DSIZE * PACK;
    localparam int PCW = $clog2(PACK + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state;
    logic             st_d;
    logic             zero_cap;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] smp_cnt;
    logic [DLY_W-1:0] delay_q;
    logic [DLY_W-1:0] dly_cnt;
    logic [PCW-1:0]   pack_cnt;
    logic [WW-1:0]    pack_reg;
`ifdef AD_PACK_RAMP_EN
    logic             ramp_sel;
    logic [DSIZE-1:0] ramp_q;
`endif

    logic             trigger;
    logic             pack_full;
    logic             last_smp;
    logic [DSIZE-1:0] sample;
    logic [WW-1:0]    pack_next;
    logic [WW-1:0]    flush_word;

    always_comb begin
        trigger = i_st & ~st_d;
`ifdef AD_PACK_RAMP_EN
        sample = ramp_sel ? ramp_q : i_ad_data;
`else
        sample = i_ad_data;
`endif
        pack_next  = (pack_reg << DSIZE) | WW'(sample);
        pack_full  = (pack_cnt == PCW'(PACK - 1));
        last_smp   = (smp_cnt == count_q - CNT_W'(1));
        // Shifting left pushes stale bits of earlier words out and zero-fills the LSBs.
        flush_word = pack_reg << (DSIZE * (PACK - int'(pack_cnt)));
    end

    always_ff @(posedge i_ad_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            st_d         <= 1'b0;
            zero_cap     <= 1'b0;
            count_q      <= '0;
            smp_cnt      <= '0;
            delay_q      <= '0;
            dly_cnt      <= '0;
            pack_cnt     <= '0;
            pack_reg     <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_last       <= 1'b0;
            o_working    <= 1'b0;
            o_done       <= 1'b0;
`ifdef AD_PACK_RAMP_EN
            ramp_sel     <= 1'b0;
            ramp_q       <= '0;
`endif
        end else begin
            st_d         <= i_st;
            o_data_valid <= 1'b0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;
            if (state != S_IDLE && i_abort) begin
                state     <= S_IDLE;
                o_working <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (trigger && !i_abort) begin
                            count_q  <= i_recv_count;
                            delay_q  <= i_delay;
                            dly_cnt  <= '0;
                            smp_cnt  <= '0;
                            pack_cnt <= '0;
`ifdef AD_PACK_RAMP_EN
                            ramp_sel <= i_ramp;
                            ramp_q   <= '0;
`endif
                            // An empty capture reports completion straight away.
                            if (i_recv_count == '0) begin
                                zero_cap <= 1'b1;
                                o_done   <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                zero_cap  <= 1'b0;
                                o_working <= 1'b1;
                                state     <= (i_delay == '0) ? S_CAPTURE : S_DELAY;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (dly_cnt == delay_q - DLY_W'(1)) begin
                            state <= S_CAPTURE;
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        pack_reg <= pack_next;
                        smp_cnt  <= smp_cnt + 1'b1;
`ifdef AD_PACK_RAMP_EN
                        ramp_q   <= ramp_q + 1'b1;
`endif
                        if (pack_full) begin
                            o_data       <= pack_next;
                            o_data_valid <= 1'b1;
                            pack_cnt     <= '0;
                        end else begin
                            pack_cnt <= pack_cnt + 1'b1;
                        end
                        if (last_smp) begin
                            if (pack_full) begin
                                o_last    <= 1'b1;
                                o_working <= 1'b0;
                                state     <= S_DONE;
                            end else begin
                                state <= S_FLUSH;
                            end
                        end
                    end
                    S_FLUSH: begin
                        o_data       <= flush_word;
                        o_data_valid <= 1'b1;
                        o_last       <= 1'b1;
                        o_working    <= 1'b0;
                        pack_cnt     <= '0;
                        state        <= S_DONE;
                    end
                    S_DONE: begin
                        o_done <= ~zero_cap;
                        state  <= S_IDLE;
                    end
                    default: begin
                        o_working <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
